// File: rtl/mux_pipe_if.sv
// rtl/mux_pipe_if.sv - channel, select and output handshake bundle for mux_pipe
interface mux_pipe_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 3,
    parameter int SELW  = 2
);
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [SELW-1:0]      sel;
    logic                 sel_load;
    logic [SELW-1:0]      sel_q;
    logic [WIDTH-1:0]     out;
    logic                 out_valid;
    logic                 out_ready;
    logic                 err;

    modport master (
        output in_data, in_valid, sel, sel_load, out_ready,
        input  in_ready, sel_q, out, out_valid, err
    );

    modport slave (
        input  in_data, in_valid, sel, sel_load, out_ready,
        output in_ready, sel_q, out, out_valid, err
    );
endinterface

// File: rtl/mux_pipe.sv
// rtl/mux_pipe.sv - registered N:1 word mux with latched select and valid/ready output
module mux_pipe #(
    parameter int WIDTH = 8,
    parameter int NCH   = 3,
    parameter int SELW  = 2
) (
    input  logic        clk,
    input  logic        reset,
    mux_pipe_if.slave   bus
);
    localparam logic [SELW:0] MAX_SEL = (SELW+1)'(NCH);

    logic [SELW-1:0]  r_sel_q;
    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;
    logic             r_err;

    logic             w_free;
    logic             w_sel_valid;
    logic [WIDTH-1:0] w_sel_data;
    logic [NCH-1:0]   w_in_ready;
    logic             w_sel_illegal;

    assign w_free        = ~r_out_valid | bus.out_ready;
    assign w_sel_illegal = {1'b0, bus.sel} > MAX_SEL;

    // Code 0 and codes above NCH match no channel, so the word/valid stay 0.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        w_in_ready  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (r_sel_q == SELW'(k + 1)) begin
                w_sel_valid   = bus.in_valid[k];
                w_sel_data    = bus.in_data[k*WIDTH +: WIDTH];
                w_in_ready[k] = w_free;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_q     <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (bus.sel_load) begin
                if (w_sel_illegal) begin
                    r_sel_q <= '0;
                    r_err   <= 1'b1;
                end else begin
                    r_sel_q <= bus.sel;
                end
            end
            // A stalled word holds regardless of any select change.
            if (w_free) begin
                if (w_sel_valid) begin
                    r_out       <= w_sel_data;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out       <= '0;
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.sel_q     = r_sel_q;
    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_mux_pipe.sv
// tb/tb_mux_pipe.sv - directed and random checks of mux_pipe against a word-queue model
module tb_mux_pipe;
    localparam int WIDTH = 8;
    localparam int NCH   = 3;
    localparam int SELW  = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mux_pipe_if #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) bus ();

    mux_pipe #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: active channel code, output word, and words in flight.
    int               m_sel;
    logic [WIDTH-1:0] m_out;
    bit               m_valid;
    bit               m_err;
    logic [WIDTH-1:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int k, input logic [WIDTH-1:0] v, input bit vld);
        bus.in_data[k*WIDTH +: WIDTH] = v;
        bus.in_valid[k] = vld;
    endtask

    // One clock: check in_ready before the edge, advance the model, check registers after it.
    task automatic tick();
        int               n_sel;
        logic [WIDTH-1:0] n_out;
        bit               n_valid, n_err, free;
        logic [NCH-1:0]   exp_rdy;
        #1;
        free    = !m_valid || bus.out_ready;
        exp_rdy = '0;
        if (free && m_sel >= 1 && m_sel <= NCH) exp_rdy[m_sel-1] = 1'b1;
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));

        n_sel = m_sel; n_out = m_out; n_valid = m_valid; n_err = 0;
        if (reset) begin
            n_sel = 0; n_out = 0; n_valid = 0;
            sb_q.delete();
        end else begin
            if (m_valid && bus.out_ready && sb_q.size() > 0)
                check("sb_order", 32'(bus.out), 32'(sb_q.pop_front()));
            if (free) begin
                if (m_sel >= 1 && m_sel <= NCH && bus.in_valid[m_sel-1]) begin
                    n_out   = bus.in_data[(m_sel-1)*WIDTH +: WIDTH];
                    n_valid = 1;
                    sb_q.push_back(n_out);
                end else begin
                    n_out = 0; n_valid = 0;
                end
            end
            if (bus.sel_load) begin
                if (int'(bus.sel) > NCH) begin
                    n_sel = 0; n_err = 1;
                end else begin
                    n_sel = int'(bus.sel);
                end
            end
        end

        @(posedge clk);
        #1;
        m_sel = n_sel; m_out = n_out; m_valid = n_valid; m_err = n_err;
        check("out", 32'(bus.out), 32'(m_out));
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check("sel_q", 32'(bus.sel_q), 32'(m_sel));
        check("err", 32'(bus.err), 32'(m_err));
        @(negedge clk);
    endtask

    initial begin
        m_sel = 0; m_out = 0; m_valid = 0; m_err = 0;
        reset         = 1'b1;
        bus.in_data   = '0;
        bus.in_valid  = '1;
        bus.sel       = '0;
        bus.sel_load  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);

        // Reset then null select with every channel valid.
        tick(); tick();
        reset = 1'b0;
        tick(); tick();

        // Select channel 1 (code 2), then four back-to-back words.
        bus.in_valid = '0;
        bus.sel = 3'd2; bus.sel_load = 1'b1;
        set_ch(1, 8'hA5, 1'b1);
        tick();
        bus.sel_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_ch(1, 8'hA5 + 8'(i), 1'b1);
            tick();
        end
        bus.in_valid = '0;
        tick(); tick();

        // Backpressure on channel 2.
        bus.sel = 3'd3; bus.sel_load = 1'b1;
        tick();
        bus.sel_load = 1'b0;
        set_ch(2, 8'h11, 1'b1); tick();
        set_ch(2, 8'h22, 1'b1); bus.out_ready = 1'b0;
        tick(); tick(); tick();
        bus.out_ready = 1'b1; tick();
        set_ch(2, 8'h33, 1'b1); tick();
        bus.in_valid = '0; tick(); tick();

        // Select change while stalled, then a transfer in the sel_load cycle.
        set_ch(2, 8'h11, 1'b1); tick();
        bus.out_ready = 1'b0; set_ch(2, 8'h44, 1'b1);
        bus.sel = 3'd1; bus.sel_load = 1'b1; tick();
        bus.sel_load = 1'b0; tick();
        bus.out_ready = 1'b1; tick();
        bus.sel = 3'd3; bus.sel_load = 1'b1; tick();
        set_ch(2, 8'h55, 1'b1); set_ch(0, 8'h66, 1'b1);
        bus.sel = 3'd1; bus.sel_load = 1'b1; tick();
        bus.sel_load = 1'b0; tick();
        bus.in_valid = '0; tick();

        // Illegal code with a word pending.
        set_ch(0, 8'h5A, 1'b1); bus.out_ready = 1'b0; tick();
        bus.in_valid = '0;
        bus.sel = 3'd5; bus.sel_load = 1'b1; tick();
        bus.sel_load = 1'b0; tick(); tick();
        bus.out_ready = 1'b1; tick(); tick();

        // Mid-stream reset discards the held word.
        bus.sel = 3'd1; bus.sel_load = 1'b1; tick();
        bus.sel_load = 1'b0; set_ch(0, 8'h77, 1'b1); tick();
        bus.out_ready = 1'b0; tick();
        reset = 1'b1; tick();
        reset = 1'b0; tick(); tick();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bus.in_data   = (NCH*WIDTH)'($urandom);
            bus.in_valid  = NCH'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.sel_load  = ($urandom_range(0, 7) == 0);
            bus.sel       = SELW'($urandom_range(0, 7));
            reset         = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0;
        bus.in_valid = '0; bus.out_ready = 1'b1; bus.sel_load = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
